// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch/issue bus between the sequencer, instruction cache, ALU flags and execute stage
interface fetch_sequencer_if;
  logic        run;
  logic [15:0] ir_in;
  logic        zf;
  logic        cf;
  logic        exec_done;
  logic [15:0] addr;
  logic        fetch_en;
  logic        issue_valid;
  logic [15:0] ir_out;
  logic        halted;
  logic [15:0] retired;
  modport master (
    input  run, ir_in, zf, cf, exec_done,
    output addr, fetch_en, issue_valid, ir_out, halted, retired
  );
  modport slave (
    output run, ir_in, zf, cf, exec_done,
    input  addr, fetch_en, issue_valid, ir_out, halted, retired
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/fetch sequencer resolving conditional jumps and halt locally, issuing the rest to execute
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HLT_OP   = 5'b11111
) (
  input logic               clk,
  input logic               rst_n,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, HALT} state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] retired_q, retired_d;
  logic [4:0]  op;
  logic [15:0] tgt;
  logic        is_jump;
  logic        taken;
  assign op      = bus.ir_in[15:11];
  assign tgt     = {8'h00, bus.ir_in[7:0]};
  assign is_jump = (op == 5'b01100) || (op == 5'b01111) || (op == 5'b10000);
  assign taken   = (op == 5'b01100) ? !bus.zf :
                   (op == 5'b01111) ? bus.cf : (bus.cf | bus.zf);
  // next-state and datapath updates, one instruction step per state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    case (state_q)
      IDLE:    state_d = bus.run ? FETCH : IDLE;
      FETCH:   state_d = DECODE;
      DECODE: begin
        if (is_jump) begin
          pc_d      = taken ? tgt : pc_q + 16'd1;
          retired_d = retired_q + 16'd1;
          state_d   = FETCH;
        end else if (op == HLT_OP) begin
          halted_d  = 1'b1;
          retired_d = retired_q + 16'd1;
          state_d   = HALT;
        end else begin
          ir_d    = bus.ir_in;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.exec_done) begin
          valid_d   = 1'b0;
          pc_d      = pc_q + 16'd1;
          retired_d = retired_q + 16'd1;
          state_d   = FETCH;
        end
      end
      default: ;
    endcase
  end
  // state and datapath registers, reset overrides every state including HALT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end
  assign bus.addr        = pc_q;
  assign bus.fetch_en    = (state_q == FETCH);
  assign bus.issue_valid = valid_q;
  assign bus.ir_out      = ir_q;
  assign bus.halted      = halted_q;
  assign bus.retired     = retired_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized and directed checks of fetch_sequencer against an instruction-level model
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_sequencer_if bus ();
  fetch_sequencer_if bw ();
  fetch_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_sequencer #(.RESET_PC(16'hFFFF)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bw));
  assign bw.run       = bus.run;
  assign bw.ir_in     = bus.ir_in;
  assign bw.zf        = bus.zf;
  assign bw.cf        = bus.cf;
  assign bw.exec_done = bus.exec_done;
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] mem [256];
  logic prev_fe = 1'b0;
  // instruction-level model: where we are inside the current instruction
  logic        m_known = 1'b0;
  logic        m_live, m_halt, m_valid;
  logic [15:0] m_pc, m_ret, m_ir;
  int          m_k;
  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic model_edge(input logic r_n, input logic rn, input logic [15:0] ir,
                            input logic z, input logic c, input logic ed);
    logic [4:0] op;
    logic jmp, tk;
    op  = ir[15:11];
    jmp = (op == 5'd12) || (op == 5'd15) || (op == 5'd16);
    tk  = (op == 5'd12 && !z) || (op == 5'd15 && c) || (op == 5'd16 && (c | z));
    if (!r_n) begin
      m_known = 1'b1; m_live = 1'b0; m_halt = 1'b0; m_valid = 1'b0;
      m_pc = 16'h0000; m_ret = 16'h0000; m_ir = 16'h0000; m_k = 0;
    end else if (!m_known || m_halt) begin
    end else if (!m_live) begin
      if (rn) begin m_live = 1'b1; m_k = 0; end
    end else if (m_k == 0) begin
      m_k = 1;
    end else if (m_k == 1) begin
      if (jmp) begin
        m_pc = tk ? {8'h00, ir[7:0]} : m_pc + 16'd1;
        m_ret = m_ret + 16'd1;
        m_k = 0;
      end else if (op == 5'd31) begin
        m_halt = 1'b1;
        m_ret = m_ret + 16'd1;
      end else begin
        m_ir = ir; m_valid = 1'b1; m_k = 2;
      end
    end else if (ed) begin
      m_valid = 1'b0;
      m_pc = m_pc + 16'd1;
      m_ret = m_ret + 16'd1;
      m_k = 0;
    end
  endtask
  task automatic step(input logic r_n, input logic rn, input logic z, input logic c, input logic ed);
    if (m_known) begin
      chk("addr", bus.addr, m_pc);
      chk("fetch_en", 16'(bus.fetch_en), 16'(m_live && !m_halt && m_k == 0));
      chk("issue_valid", 16'(bus.issue_valid), 16'(m_valid));
      chk("ir_out", bus.ir_out, m_ir);
      chk("halted", 16'(bus.halted), 16'(m_halt));
      chk("retired", bus.retired, m_ret);
    end
    rst_n = r_n;
    bus.run = rn;
    bus.zf = z;
    bus.cf = c;
    bus.exec_done = ed;
    if (bus.fetch_en === 1'b1) bus.ir_in = mem[bus.addr[7:0]];
    else if (!prev_fe) bus.ir_in = 16'($urandom);
    prev_fe = (bus.fetch_en === 1'b1);
    model_edge(r_n, rn, bus.ir_in, z, c, ed);
    @(negedge clk);
  endtask
  task automatic boot();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask
  task automatic jt(input string tag, input logic [15:0] ins, input logic z, input logic c,
                    input logic [15:0] exp);
    mem[0] = ins;
    boot();
    step(1'b1, 1'b0, z, c, 1'b1);
    step(1'b1, 1'b0, z, c, 1'b1);
    chk(tag, bus.addr, exp);
    chk({tag, "_fe"}, 16'(bus.fetch_en), 16'd1);
  endtask
  function automatic logic [15:0] rand_ins();
    logic [4:0] op;
    int r;
    r = $urandom_range(9);
    if (r < 2) return {5'd12, 11'($urandom)};
    if (r == 2) return {5'd15, 11'($urandom)};
    if (r == 3) return {5'd16, 11'($urandom)};
    if (r == 4 && $urandom_range(7) == 0) return {5'd31, 11'($urandom)};
    op = 5'($urandom);
    while (op == 5'd12 || op == 5'd15 || op == 5'd16 || op == 5'd31) op = 5'($urandom);
    return {op, 11'($urandom)};
  endfunction
  initial begin
    int nf, nv;
    bus.run = 1'b0; bus.zf = 1'b0; bus.cf = 1'b0; bus.exec_done = 1'b0; bus.ir_in = 16'h0000;
    fill(16'h0405);
    @(negedge clk);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("idle_addr", bus.addr, 16'h0000);
    chk("idle_fe", 16'(bus.fetch_en), 16'd0);
    boot();
    nf = 0;
    for (int i = 0; i < 9; i++) begin
      if (bus.fetch_en) begin
        chk("sl_addr", bus.addr, 16'(nf));
        nf++;
      end
      if (i % 3 == 2) chk("sl_ir_out", bus.ir_out, 16'h0405);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("sl_fetches", 16'(nf), 16'd3);
    chk("sl_retired", bus.retired, 16'd3);
    chk("sl_addr3", bus.addr, 16'd3);
    jt("jne_taken", 16'h6415, 1'b0, 1'b0, 16'h0015);
    jt("jne_not", 16'h6415, 1'b1, 1'b0, 16'h0001);
    jt("jls_taken", 16'h8422, 1'b1, 1'b0, 16'h0022);
    jt("jlo_not", 16'h7C16, 1'b0, 1'b0, 16'h0001);
    jt("jlo_taken", 16'h7C16, 1'b0, 1'b1, 16'h0016);
    mem[0] = 16'h1234;
    boot();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.issue_valid) nv++;
      chk("bp_ir_out", bus.ir_out, 16'h1234);
      chk("bp_addr", bus.addr, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (bus.issue_valid) nv++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_valid_cycles", 16'(nv), 16'd5);
    chk("bp_valid_low", 16'(bus.issue_valid), 16'd0);
    chk("bp_addr_after", bus.addr, 16'h0001);
    mem[0] = 16'h6429;
    mem[8'h29] = 16'hF800;
    boot();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hlt_halted", 16'(bus.halted), 16'd1);
    chk("hlt_retired", bus.retired, 16'd2);
    for (int i = 0; i < 10; i++) begin
      chk("hlt_addr", bus.addr, 16'h0029);
      chk("hlt_fe", 16'(bus.fetch_en), 16'd0);
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    fill(16'h0405);
    boot();
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_valid", 16'(bus.issue_valid), 16'd1);
    chk("mid_retired1", bus.retired, 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_retired0", bus.retired, 16'd0);
    chk("mid_valid0", 16'(bus.issue_valid), 16'd0);
    chk("mid_ir_out", bus.ir_out, 16'h0000);
    chk("mid_addr", bus.addr, 16'h0000);
    chk("wrap_rst", bw.addr, 16'hFFFF);
    boot();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_addr", bw.addr, 16'h0000);
    chk("wrap_retired", bw.retired, 16'd1);
    chk("wrap_main_addr", bus.addr, 16'h0001);
    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < 256; i++) mem[i] = rand_ins();
      boot();
      repeat (300)
        step(1'($urandom_range(99) != 0), 1'($urandom_range(3) != 0),
             1'($urandom), 1'($urandom), 1'($urandom));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
